// File: rtl/npu_feeder.sv
// npu_feeder: packs words into NPU lanes, runs one job, streams results out.
// Optional watchdog on RUN enabled by defining NPU_FEEDER_TIMEOUT_EN.
module npu_feeder #(
  parameter int DATA_W = 16,
  parameter int LANES = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_last,
  output logic                           npu_rst,
  output logic                           npu_enable,
  output logic [LANES-1:0][DATA_W-1:0]   npu_raw_in,
  input  logic [LANES-1:0][DATA_W-1:0]   npu_raw_out,
  input  logic                           npu_done,
  output logic                           busy,
  output logic                           err,
  output logic [7:0]                     job_count
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [2:0] {LOAD, CLEAR, RUN, DRAIN, ERR} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic up;
  logic [LANES-1:0][DATA_W-1:0] result;
  logic last_idx;
  assign last_idx = idx == IW'(LANES - 1);
`ifdef NPU_FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
  assign err = state == ERR;
`else
  assign err = TIMEOUT_CYCLES < 0;
`endif
  // up keeps in_ready and npu_rst low while reset is asserted
  assign in_ready = up && state == LOAD;
  assign npu_rst = up && state != CLEAR;
  assign npu_enable = state == RUN;
  assign out_valid = state == DRAIN;
  assign out_last = out_valid && last_idx;
  assign out_data = out_valid ? result[idx] : '0;
  assign busy = state != LOAD;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
      idx <= '0;
      up <= 1'b0;
      npu_raw_in <= '0;
      result <= '0;
      job_count <= '0;
`ifdef NPU_FEEDER_TIMEOUT_EN
      wd <= '0;
`endif
    end else begin
      up <= 1'b1;
      case (state)
        LOAD: if (in_valid && in_ready) begin
          npu_raw_in[idx] <= in_data;
          idx <= last_idx ? '0 : idx + 1'b1;
          if (last_idx) state <= CLEAR;
        end
        CLEAR: begin
          state <= RUN;
`ifdef NPU_FEEDER_TIMEOUT_EN
          wd <= '0;
`endif
        end
        RUN: if (npu_done) begin
          result <= npu_raw_out;
          state <= DRAIN;
        end
`ifdef NPU_FEEDER_TIMEOUT_EN
        else if (wd == WW'(TIMEOUT_CYCLES - 1)) state <= ERR;
        else wd <= wd + 1'b1;
`endif
        DRAIN: if (out_ready) begin
          idx <= last_idx ? '0 : idx + 1'b1;
          if (last_idx) begin
            job_count <= job_count + 8'd1;
            state <= LOAD;
          end
        end
        default: state <= ERR;
      endcase
    end
  end
endmodule

// File: tb/tb_npu_feeder.sv
// tb_npu_feeder: scoreboard bench for npu_feeder with a behavioral echo NPU.
module tb_npu_feeder;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [15:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1;
  logic [15:0] out_data;
  logic out_last;
  logic npu_rst, npu_enable, npu_done, busy, err;
  logic [3:0][15:0] npu_raw_in, npu_raw_out;
  logic [7:0] job_count;
  int errors = 0, checks = 0;
  int cnt = 0, en_cyc = 0, rst_cyc = 0;
  bit hang = 0, bp = 0;
  logic [16:0] exp_q[$];
  logic [7:0] exp_jc = 0;

  npu_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .npu_rst(npu_rst), .npu_enable(npu_enable), .npu_raw_in(npu_raw_in),
    .npu_raw_out(npu_raw_out), .npu_done(npu_done), .busy(busy), .err(err),
    .job_count(job_count)
  );

  always #5 clk = ~clk;

  // NPU model: done during the 8th enabled cycle, lanes echoed only while done
  always @(posedge clk) cnt <= npu_enable ? cnt + 1 : 0;
  assign npu_done = !hang && npu_enable && cnt == 7;
  assign npu_raw_out = npu_done ? npu_raw_in : ~npu_raw_in;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (npu_enable) en_cyc++;
    if (rst && !npu_rst) rst_cyc++;
    if (rst && out_valid && out_ready) begin
      check("in_ready_drain", in_ready, 0);
      if (exp_q.size() == 0) check("extra_out", {out_last, out_data}, 0);
      else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e[15:0]);
        check("out_last", out_last, e[16]);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp ? ~out_ready : 1'b1;
  end

  task automatic send(input logic [15:0] w);
    int n = 0;
    in_valid = 1;
    in_data = w;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 0;
        break;
      end
      if (++n > 200) begin
        check("in_timeout", 0, 1);
        in_valid = 0;
        break;
      end
    end
  endtask

  task automatic load(input logic [3:0][15:0] w, input int gap, input bit push);
    en_cyc = 0;
    rst_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      if (push) exp_q.push_back({i == 3, w[i]});
      send(w[i]);
      if (i < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic finish_job(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      check({tag, "_drain_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    exp_jc++;
    check({tag, "_job_count"}, job_count, exp_jc);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic wait_en();
    int n = 0;
    while (!npu_enable && n < 100) begin @(posedge clk); #1; n++; end
    check("enable_rise", npu_enable, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_npu_rst"}, npu_rst, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_enable"}, npu_enable, 0);
    check({tag, "_raw_in"}, npu_raw_in, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_job_count"}, job_count, 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_npu_rst", npu_rst, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    release_rst();

    load({16'd4, 16'd3, 16'd2, 16'd1}, 0, 1);
    finish_job("basic");
    check("basic_raw_in", npu_raw_in, {16'd4, 16'd3, 16'd2, 16'd1});
    check("basic_rst_cycles", rst_cyc, 1);
    check("basic_en_cycles", en_cyc, 8);

    bp = 1;
    load({16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA}, 0, 1);
    finish_job("bp");
    bp = 0;

    load({16'h0, 16'h0, 16'h0, 16'h0}, 2, 1);
    finish_job("sparse");
    check("sparse_raw_in", npu_raw_in, 0);

`ifdef NPU_FEEDER_TIMEOUT_EN
    begin
      int k = 0;
      hang = 1;
      load({16'd8, 16'd7, 16'd6, 16'd5}, 0, 0);
      wait_en();
      while (!err && k < 100) begin @(posedge clk); #1; k++; end
      check("wd_cycles", k, 32);
      check("wd_enable", npu_enable, 0);
      check("wd_in_ready", in_ready, 0);
      check("wd_out_valid", out_valid, 0);
      repeat (10) begin @(posedge clk); #1; end
      check("wd_err_sticky", err, 1);
      check("wd_busy", busy, 1);
      hang = 0;
      rst = 0;
      #1;
      check("wd_rst_err", err, 0);
      @(posedge clk);
      release_rst();
      exp_jc = 0;
    end
`endif

    load({16'd99, 16'd98, 16'd97, 16'd96}, 0, 0);
    wait_en();
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    #1;
    check_reset_vals("midrun");
    exp_jc = 0;
    repeat (2) @(posedge clk);
    release_rst();
    load({16'd40, 16'd30, 16'd20, 16'd10}, 0, 1);
    finish_job("after_rst");
    check("after_rst_raw_in", npu_raw_in, {16'd40, 16'd30, 16'd20, 16'd10});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/npu_feeder.md
# npu_feeder

Job sequencer that drives the initiator side of the NPU lane interface. It packs a 16-bit word stream into the four NPU input lanes and pulses the NPU reset before each job. It then holds enable until the NPU raises done, captures the four result lanes, and serializes them onto a downstream valid/ready stream. It sits between the host/DMA word stream and the NPU core.

## Interface
Parameters:
- DATA_W, 16, lane/word width
- LANES, 4, number of NPU lanes
- TIMEOUT_CYCLES, 32, maximum RUN cycles without npu_done (watchdog only)

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word ready
- in_data  in  DATA_W  upstream word
- out_valid  out  1  result word valid
- out_ready  in  1  downstream ready
- out_data  out  DATA_W  result word
- out_last  out  1  marks lane LANES-1 result word
- npu_rst  out  1  active-low reset to NPU
- npu_enable  out  1  NPU enable
- npu_raw_in  out  DATA_W x LANES  NPU input lanes
- npu_raw_out  in  DATA_W x LANES  NPU result lanes
- npu_done  in  1  NPU job complete
- busy  out  1  state is not LOAD
- err  out  1  sticky watchdog error
- job_count  out  8  completed jobs, wraps 255->0

## Operation
State machine: LOAD, CLEAR, RUN, DRAIN, ERR.
- LOAD:
  - in_ready=1.
  - Each accepted word (in_valid&&in_ready) is written to lane idx; idx increments.
  - Idle cycles between words are allowed.
  - The accept that writes lane LANES-1 moves the state to CLEAR and resets idx to 0.
- CLEAR:
  - Lasts exactly 1 cycle.
  - npu_rst=0, npu_enable=0.
  - npu_done is ignored.
  - Moves to RUN.
- RUN:
  - npu_enable=1; npu_raw_in is held stable.
  - The first cycle with npu_done=1 captures npu_raw_out into the result registers and moves to DRAIN.
- DRAIN:
  - out_valid=1, out_data=result[idx], out_last=(idx==LANES-1).
  - idx advances on out_valid&&out_ready.
  - The last handshake increments job_count and returns to LOAD.
- ERR:
  - Entered only when the watchdog fires.
  - err=1, with in_ready, out_valid and npu_enable all 0.
  - Exits only by reset.
- Result registers are separate from the npu_raw_in lane registers. npu_raw_in retains the last job's lanes until they are overwritten.

## Timing
- Reset values:
  - state=LOAD, idx=0.
  - in_ready=0 while rst=0; it is 1 from the first edge after release.
  - out_valid=0, out_last=0, out_data=0.
  - npu_rst=0 while rst=0; it goes 1 on the first edge after release.
  - npu_enable=0, npu_raw_in all 0, busy=0, err=0, job_count=0.
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid or out_ready to any output.
- 4th word accepted at edge N:
  - npu_rst low during cycle N..N+1.
  - npu_enable high from edge N+1.
- npu_done sampled at edge M:
  - npu_enable low from edge M.
  - out_valid high from edge M.
  - The captured values are those present on npu_raw_out at edge M.
- Minimum job time: 1 CLEAR cycle + NPU compute cycles (count reaches 8) + LANES drain cycles.
- Reset mid-operation: all state returns to reset values immediately; the partial job and results are discarded.
- npu_done held high across the CLEAR->RUN boundary is honored only in RUN.
- A word offered on in_valid during CLEAR/RUN/DRAIN is not accepted and must be held by the source.

## Configuration
- NPU_FEEDER_TIMEOUT_EN defined:
  - A watchdog counter clears on RUN entry and increments every RUN cycle.
  - If it reaches TIMEOUT_CYCLES without npu_done, the next state is ERR.
  - npu_done arriving on the same cycle as the limit wins, and the block goes to DRAIN.
- NPU_FEEDER_TIMEOUT_EN undefined:
  - No watchdog; RUN waits indefinitely.
  - err is tied 0; ERR is unreachable.

## Test plan
- Reset:
  - Hold rst=0 for 3 cycles.
  - All outputs at reset values; in_ready=1 and npu_rst=1 one edge after release.
- Basic job:
  - Feed 1,2,3,4 into a behavioral NPU that asserts done after 8 enabled cycles and echoes its lanes.
  - npu_raw_in={1,2,3,4}, npu_rst low for exactly 1 cycle, and enable high for 8 cycles.
  - Outputs 1,2,3,4 with out_last on 4; job_count=1.
- Backpressure:
  - Job 0xAAAA,0x5555,0xAAAA,0x5555 with out_ready low on alternate cycles.
  - All four words delivered once, in order; in_ready=0 throughout DRAIN.
- Sparse input:
  - Words 0,0,0,0 with 2 idle cycles between each.
  - Lanes fill in order; the job completes with results 0,0,0,0.
- Watchdog (macro defined):
  - The NPU model never asserts done.
  - err=1 exactly 32 RUN cycles after enable rises; npu_enable=0.
  - State stays ERR until rst.
- Reset mid-RUN:
  - Assert rst on RUN cycle 3.
  - Outputs return to reset values and job_count stays 0.
  - The subsequent job 10,20,30,40 returns 10,20,30,40.
